// File: rtl/sub64_seq.sv
// sub64_seq: multi-cycle 64-bit subtractor (a - b) with Y86 condition codes.
// One CHUNK-wide adder slice evaluates a + ~b + 1 over 64/CHUNK cycles.
module sub64_seq #(
  parameter int unsigned CHUNK = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] diff,
  output logic        of,
  output logic        zf,
  output logic        sf
);

  localparam int unsigned N  = 64 / CHUNK;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = CHUNK + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  logic [63:0]     a_r;
  logic [63:0]     nb_r;
  logic [63:0]     acc;
  logic [IW-1:0]   idx;
  logic            carry;

  logic [5:0]      base;
  logic [CHUNK:0]  sum;
  logic [63:0]     acc_next;
  logic            last;

  // Shared adder slice: current chunk sum and the accumulator with it merged in
  always_comb begin
    base     = 6'(32'(idx) * CHUNK);
    sum      = {1'b0, a_r[base +: CHUNK]} + {1'b0, nb_r[base +: CHUNK]} + CW'(carry);
    acc_next = acc;
    acc_next[base +: CHUNK] = sum[CHUNK-1:0];
    last     = (idx == IW'(N - 1));
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      a_r   <= '0;
      nb_r  <= '0;
      acc   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      of    <= 1'b0;
      zf    <= 1'b0;
      sf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            nb_r  <= ~b;
            carry <= 1'b1;
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          carry <= sum[CHUNK];
          idx   <= idx + IW'(1);
          if (last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= acc_next;
            sf    <= acc_next[63];
            zf    <= (acc_next == 64'd0);
            // operands of equal sign in a + ~b yet result sign flipped
            of    <= (a_r[63] == nb_r[63]) && (acc_next[63] != a_r[63]);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
